nes_flash_arbiter: RTL

Shares the single external flash read port between the CPU PRG-ROM path and the PPU CHR-ROM path. Each requester presents a full 23-bit flash byte address with a level request and receives a one-cycle acknowledge with registered read data. Internally it is a round-robin arbiter plus a fixed-wait access sequencer. It sits between the mapper/address-extension logic and the flash pins, and replaces direct mapper-to-flash address wiring.

---
 rtl/nes_flash_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/nes_flash_arbiter.sv
// rtl/nes_flash_arbiter.sv - round-robin CPU/PPU arbiter and fixed-wait sequencer for the shared flash read port
module nes_flash_arbiter #(
    parameter int FL_WAIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpu_req,
    input  logic [22:0] i_cpu_addr,
    output logic        o_cpu_ack,
    output logic [7:0]  o_cpu_rdata,
    input  logic        i_ppu_req,
    input  logic [22:0] i_ppu_addr,
    output logic        o_ppu_ack,
    output logic [7:0]  o_ppu_rdata,
    output logic [22:0] o_fl_addr,
    output logic        o_fl_ce_n,
    output logic        o_fl_oe_n,
    input  logic [7:0]  i_fl_rdata,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic       OWN_CPU  = 1'b0;
    localparam logic       OWN_PPU  = 1'b1;
    localparam logic [3:0] CNT_LOAD = 4'(FL_WAIT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner;
    logic        r_last_grant;
    logic [3:0]  r_cnt;
    logic [22:0] r_fl_addr;
    logic        r_fl_ce_n;
    logic        r_fl_oe_n;
    logic        r_cpu_ack;
    logic        r_ppu_ack;
    logic [7:0]  r_cpu_rdata;
    logic [7:0]  r_ppu_rdata;

    logic        w_grant;
    logic        w_grant_owner;
    logic        w_access_end;

    // Ties go to whichever port did not win last; DONE never grants so a
    // requester that drops req on seeing ack cannot trigger a second access.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant       = 1'b0;
        w_grant_owner = r_owner;
        w_access_end  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cpu_req && i_ppu_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = (r_last_grant == OWN_CPU) ? OWN_PPU : OWN_CPU;
                end else if (i_cpu_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = OWN_CPU;
                end else if (i_ppu_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = OWN_PPU;
                end
                if (w_grant) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_access_end = 1'b1;
                    w_state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner      <= OWN_CPU;
            r_last_grant <= OWN_PPU;
            r_cnt        <= 4'd0;
            r_fl_addr    <= 23'd0;
            r_fl_ce_n    <= 1'b1;
            r_fl_oe_n    <= 1'b1;
            r_cpu_ack    <= 1'b0;
            r_ppu_ack    <= 1'b0;
            r_cpu_rdata  <= 8'd0;
            r_ppu_rdata  <= 8'd0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_ppu_ack <= 1'b0;
            if (w_grant) begin
                r_owner      <= w_grant_owner;
                r_last_grant <= w_grant_owner;
                r_fl_addr    <= (w_grant_owner == OWN_CPU) ? i_cpu_addr : i_ppu_addr;
                r_fl_ce_n    <= 1'b0;
                r_fl_oe_n    <= 1'b0;
                r_cnt        <= CNT_LOAD;
            end
            if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access_end) begin
                r_fl_ce_n <= 1'b1;
                r_fl_oe_n <= 1'b1;
                if (r_owner == OWN_CPU) begin
                    r_cpu_rdata <= i_fl_rdata;
                    r_cpu_ack   <= 1'b1;
                end else begin
                    r_ppu_rdata <= i_fl_rdata;
                    r_ppu_ack   <= 1'b1;
                end
            end
        end
    end

    assign o_cpu_ack   = r_cpu_ack;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_ppu_ack   = r_ppu_ack;
    assign o_ppu_rdata = r_ppu_rdata;
    assign o_fl_addr   = r_fl_addr;
    assign o_fl_ce_n   = r_fl_ce_n;
    assign o_fl_oe_n   = r_fl_oe_n;
    assign o_busy      = (r_state != ST_IDLE);

endmodule
